// File: rtl/instr_encoder_loader.sv
// RV32I field encoder that streams encoded words into instruction memory.
// Optional build macro LOADER_IMM_CHECK_EN: enforce a 12-bit signed immediate range for LOAD, I-ALU and STORE.
module instr_encoder_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: a field set is taken on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and start blocks acceptance in its own cycle.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] C_R      = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_IALU   = 3'd4;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [31:0]       enc;
    logic              illegal;
    logic              range_bad;
    logic              bad;
    logic              write;
    logic [ADDR_W:0]   count_inc;

`ifdef LOADER_IMM_CHECK_EN
    assign range_bad = ((in_class == C_LOAD) || (in_class == C_STORE) || (in_class == C_IALU))
                       && (imm[12] != imm[11]);
`else
    assign range_bad = 1'b0;
`endif

    always_comb begin
        enc     = '0;
        illegal = 1'b0;
        case (in_class)
            C_R:      enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            C_LOAD:   enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            C_STORE:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            C_BRANCH: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            C_IALU:   enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            default:  illegal = 1'b1;
        endcase
    end

    // A misaligned branch target is refused like an illegal class.
    assign bad       = illegal || range_bad || ((in_class == C_BRANCH) && imm[0]);
    assign count_inc = count + (ADDR_W+1)'(1);
    assign full      = (state == S_FULL);
    assign err       = (state == S_ERR);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        write     = 1'b0;
        in_ready  = (state == S_LOAD) && !start;
        if (start) begin
            state_nxt = S_LOAD;
        end else if (in_valid && in_ready) begin
            if (bad) begin
                state_nxt = S_ERR;
            end else begin
                write = 1'b1;
                if (count_inc == DEPTH_C) state_nxt = S_FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= write;
            if (write) begin
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= enc;
            end
            if (start)      count <= '0;
            else if (write) count <= count_inc;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: spec-level model checked every cycle plus literal write expectations.
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+31:0] exp_q[$];

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .err(err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Spec-level model: instruction words assembled by arithmetic placement of fields.
    function automatic logic [31:0] model_enc(input int c, input int d, input int s1, input int s2,
                                              input int f3, input int f7, input int im);
        int unsigned u;
        int unsigned w;
        u = 32'(im);
        w = 0;
        case (c)
            0: w = 32'h33 + (f7 << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7);
            1: w = 32'h03 + ((u & 32'hFFF) << 20) + (s1 << 15) + (f3 << 12) + (d << 7);
            4: w = 32'h13 + ((u & 32'hFFF) << 20) + (s1 << 15) + (f3 << 12) + (d << 7);
            2: w = 32'h23 + (((u >> 5) & 32'h7F) << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12)
                   + ((u & 32'h1F) << 7);
            3: w = 32'h63 + (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3F) << 25) + (s2 << 20)
                   + (s1 << 15) + (f3 << 12) + (((u >> 1) & 32'hF) << 8) + (((u >> 11) & 1) << 7);
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input int c, input int im);
        int sv;
        sv = (im >= 4096) ? im - 8192 : im;
        if (c > 4) return 1'b0;
        if (c == 3 && (im % 2) != 0) return 1'b0;
`ifdef LOADER_IMM_CHECK_EN
        if ((c == 1 || c == 2 || c == 4) && (sv < -2048 || sv > 2047)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // modes: 0 idle, 1 loading, 2 full, 3 error
    int          m_mode  = 0;
    int          m_count = 0;
    bit          m_we    = 1'b0;
    int          m_addr  = 0;
    logic [31:0] m_data  = '0;

    always @(posedge clk) begin : model_and_compare
        bit rdy;
        logic [ADDR_W+31:0] lit;
        rdy = (m_mode == 1) && !start;
        if (!reset_n) begin
            m_mode = 0; m_count = 0; m_we = 1'b0; m_addr = 0; m_data = '0;
        end else begin
            m_we = 1'b0;
            if (start) begin
                m_count = 0;
                m_mode  = 1;
            end else if (rdy && in_valid) begin
                if (model_legal(int'(in_class), int'(imm))) begin
                    m_we   = 1'b1;
                    m_addr = m_count;
                    m_data = model_enc(int'(in_class), int'(rd), int'(rs1), int'(rs2),
                                       int'(funct3), int'(funct7), int'(imm));
                    m_count++;
                    if (m_count == DEPTH) m_mode = 2;
                end else begin
                    m_mode = 3;
                end
            end
        end
        #1;
        check("cyc_in_ready", 32'(in_ready), 32'((m_mode == 1) && !start));
        check("cyc_mem_we", 32'(mem_we), 32'(m_we));
        check("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
        check("cyc_mem_wdata", mem_wdata, m_data);
        check("cyc_count", 32'(count), 32'(m_count));
        check("cyc_full", 32'(full), 32'(m_mode == 2));
        check("cyc_err", 32'(err), 32'(m_mode == 3));
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("lit_unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                lit = exp_q.pop_front();
                check("lit_addr", 32'(mem_addr), 32'(lit[ADDR_W+31:32]));
                check("lit_data", mem_wdata, lit[31:0]);
            end
        end
    end

    // driver tasks: all begin and end at a falling edge
    task automatic pulse_start();
        start = 1'b1;
        #1;
        check("start_cycle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] im, input int budget, input bit exp_acc);
        bit acc;
        acc = 1'b0;
        in_class = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < budget && !acc; i++) begin
            #1;
            if (in_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("handshake_accept", 32'(acc), 32'(exp_acc));
    endtask

    task automatic push_lit(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_class = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 0);

        // single R-type
        pulse_start();
        push_lit(0, 32'h002081B3);
        send(0, 3, 1, 2, 0, 0, 0, 8, 1);
        check("r_we", 32'(mem_we), 1);
        check("r_addr", 32'(mem_addr), 0);
        check("r_data", mem_wdata, 32'h002081B3);
        check("r_count", 32'(count), 1);
        @(negedge clk);
        check("r_we_drop", 32'(mem_we), 0);

        // LOAD, STORE, I-ALU back to back with ignored fields set to junk
        pulse_start();
        push_lit(0, 32'h00852283);
        push_lit(1, 32'hFE612E23);
        push_lit(2, 32'hFFF10093);
        send(1, 5, 10, 31, 2, 7'h7F, 13'd8, 8, 1);
        check("ld_data", mem_wdata, 32'h00852283);
        send(2, 31, 2, 6, 2, 7'h7F, 13'h1FFC, 1, 1);
        check("st_addr", 32'(mem_addr), 1);
        check("st_data", mem_wdata, 32'hFE612E23);
        send(4, 1, 2, 31, 0, 7'h55, 13'h1FFF, 1, 1);
        check("ialu_data", mem_wdata, 32'hFFF10093);
        check("ialu_count", 32'(count), 3);
        @(negedge clk);

        // branch aligned, then misaligned, then recovery
        pulse_start();
        push_lit(0, 32'hFE208CE3);
        send(3, 31, 1, 2, 0, 7'h7F, 13'h1FF8, 8, 1);
        check("br_data", mem_wdata, 32'hFE208CE3);
        send(3, 0, 1, 2, 0, 0, 13'h1FF9, 8, 1);
        check("br_mis_err", 32'(err), 1);
        check("br_mis_we", 32'(mem_we), 0);
        check("br_mis_ready", 32'(in_ready), 0);
        check("br_mis_count", 32'(count), 1);
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(err), 1);
        pulse_start();
        check("restart_err", 32'(err), 0);
        check("restart_count", 32'(count), 0);
        push_lit(0, 32'h002081B3);
        send(0, 3, 1, 2, 0, 0, 0, 8, 1);
        check("restart_addr", 32'(mem_addr), 0);
        @(negedge clk);

        // fill to DEPTH, fifth word held off
        pulse_start();
        push_lit(0, 32'h002080B3);
        push_lit(1, 32'h00208133);
        push_lit(2, 32'h002081B3);
        push_lit(3, 32'h00208233);
        for (int i = 1; i <= 4; i++) send(0, 5'(i), 1, 2, 0, 0, 0, 8, 1);
        check("fill_addr", 32'(mem_addr), 3);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        send(0, 5, 1, 2, 0, 0, 0, 5, 0);
        check("fill_hold_count", 32'(count), 4);
        check("fill_hold_full", 32'(full), 1);

        // illegal class
        pulse_start();
        send(6, 1, 1, 1, 0, 0, 0, 8, 1);
        check("ill_err", 32'(err), 1);
        check("ill_we", 32'(mem_we), 0);
        check("ill_count", 32'(count), 0);

        // reset mid-stream drops the pending word
        pulse_start();
        push_lit(0, 32'h00208133);
        send(0, 2, 1, 2, 0, 0, 0, 8, 1);
        in_class = 0; rd = 3; rs1 = 1; rs2 = 2; funct3 = 0; funct7 = 0; imm = 0;
        in_valid = 1'b1;
        reset_n  = 1'b0;
        @(negedge clk);
        check("mid_rst_we", 32'(mem_we), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_count", 32'(count), 0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        check("mid_rst_idle_ready", 32'(in_ready), 0);

        // start together with reset: reset wins, so the loader stays idle
        start   = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        #1;
        check("rst_beats_start", 32'(in_ready), 0);
        @(negedge clk);

        // immediate range edge
        pulse_start();
`ifdef LOADER_IMM_CHECK_EN
        send(1, 5, 10, 0, 2, 0, 13'h0800, 8, 1);
        check("imm_rng_err", 32'(err), 1);
        check("imm_rng_we", 32'(mem_we), 0);
`else
        push_lit(0, 32'h80052283);
        send(1, 5, 10, 0, 2, 0, 13'h0800, 8, 1);
        check("imm_rng_err", 32'(err), 0);
        check("imm_rng_data", mem_wdata, 32'h80052283);
`endif
        repeat (2) @(negedge clk);
        check("lit_queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes RV32I instruction fields into 32-bit instruction words and writes them sequentially into instruction memory.
- Emits exactly the opcodes the control unit decodes: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, I-ALU 0010011.
- Used by the test/boot path to build programs for the datapath.
- Valid/ready input, registered single-stage encode pipeline, word-address counter, fill/error FSM.

Parameters:
- DEPTH, 64, number of instruction words the loader may write per session.
- ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  pulse: begin new load session at address 0.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader accepts fields this cycle.
- in_class  input  3  0=R, 1=LOAD, 2=STORE, 3=BRANCH, 4=I-ALU, 5-7 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R only).
- imm  input  13  signed immediate; I/S use imm[11:0], B uses imm[12:1].
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  words accepted this session.
- full  output  1  DEPTH words accepted.
- err  output  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0. Any pending write is dropped.
- States:
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready = !start.
  - FULL: in_ready=0, full=1.
  - ERR: in_ready=0, err=1.
- start in any state: count=0, full=0, err=0, next state LOAD. No input is accepted in the start cycle.
- Accept happens when in_valid && in_ready. On accept at edge N:
  - mem_wdata = encoding.
  - mem_addr = count (pre-increment value).
  - mem_we=1 for exactly the cycle after edge N.
  - count increments.
  - Latency is 1 cycle; throughput is 1 word per cycle back-to-back.
- mem_we=0 in every cycle that follows a non-accept edge. mem_addr and mem_wdata hold their last values.
- A write already registered completes at its original address even if start arrives in the same cycle.
- Encodings:
  - R: funct7 | rs2 | rs1 | funct3 | rd | op.
  - LOAD, I-ALU: imm[11:0] | rs1 | funct3 | rd | op.
  - STORE: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | op.
  - BRANCH: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | op.
- Field truncation: funct7 is ignored for non-R classes. rd is ignored for STORE and BRANCH. rs2 is ignored for LOAD and I-ALU.
- Errors: an illegal class, or BRANCH with imm[0]=1 (misaligned), on a valid&&ready cycle:
  - no write and no count increment;
  - next state ERR.
- Full: the accept that makes count==DEPTH goes to FULL; that word is still written. in_valid while in FULL is ignored; the upstream source stalls.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: LOADER_IMM_CHECK_EN.
- Defined: for LOAD, I-ALU and STORE, imm[12] must equal imm[11] (12-bit signed range). A violation is treated as an error: no write, go to ERR.
- Undefined: imm[12] is silently ignored for those classes.

Test Plan:
- start, then R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3, count=1.
- LOAD rd=5 rs1=10 f3=2 imm=8, then STORE rs1=2 rs2=6 f3=2 imm=-4 back-to-back -> writes 0x00852283 at addr 0 and 0xFE612E23 at addr 1 on consecutive cycles; in_ready stays high.
- BRANCH rs1=1 rs2=2 f3=0 imm=-8 -> 0xFE208CE3. Same with imm=-7 -> no write, err=1, in_ready=0. Then start -> err=0, count=0, next word goes to addr 0.
- DEPTH=4: 5 valid R instructions streamed -> writes at addresses 0-3, full=1 after the 4th accept, 5th held (in_ready=0), count=4.
- Illegal class 6 -> ERR with no write. Separately, reset_n low mid-stream -> all outputs are 0 the next cycle and the pending write is dropped.
- With LOADER_IMM_CHECK_EN: LOAD imm=0x0800 -> err=1, no write. Without the macro -> writes imm[11:0]=0x800, err=0.
